// File: rtl/cdb_arbiter_if.sv
// Common data bus interface: FU requests and payloads in, registered CDB broadcast out.
// The master modport is the FU side; the slave modport is the arbiter.
interface cdb_arbiter_if #(
   parameter int NUM_REQ   = 5,
   parameter int PAYLOAD_W = 38
);
   logic                           flush;
   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload;
   logic [PAYLOAD_W:0]             cdb;
   logic [NUM_REQ-1:0]             grant;
   logic                           conflict;

   modport master (
      output flush, req, req_payload,
      input  cdb, grant, conflict
   );

   modport slave (
      input  flush, req, req_payload,
      output cdb, grant, conflict
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: picks one FU per cycle and registers its payload onto the
// bus for a single cycle; the previous winner is masked for one arbitration.
module cdb_arbiter #(
   parameter int NUM_REQ   = 5,
   parameter int PAYLOAD_W = 38,
   parameter int PTR_W     = 3
) (
   input  logic          clk,
   input  logic          rst,
   cdb_arbiter_if.slave  bus
);

   logic [PAYLOAD_W:0]   cdb_q;
   logic [NUM_REQ-1:0]   grant_q;
   logic                 conflict_q;
   logic [PTR_W-1:0]     ptr_q;

   logic [NUM_REQ-1:0]   elig;
   logic [PTR_W-1:0]     ptr_eff;
   logic                 found;
   logic [PTR_W-1:0]     win_idx;
   logic [NUM_REQ-1:0]   win_onehot;
   logic [PAYLOAD_W-1:0] win_payload;
   logic [PTR_W-1:0]     ptr_next;
   logic                 conflict_next;

   // The mask is always last cycle's grant, so grant_q doubles as the mask register.
   assign elig    = bus.req & ~grant_q;
   assign ptr_eff = (ptr_q >= PTR_W'(NUM_REQ)) ? '0 : ptr_q;

   always_comb begin : scan
      int cand;
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      found       = 1'b0;
      win_idx     = '0;
      win_payload = '0;
      cand        = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = int'(ptr_eff) + off;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found && elig[cand]) begin
            found   = 1'b1;
            win_idx = PTR_W'(cand);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (found && int'(win_idx) == i) begin
            win_payload = bus.req_payload[i*PAYLOAD_W +: PAYLOAD_W];
         end
      end
   end

   assign win_onehot    = found ? (NUM_REQ'(1) << win_idx) : '0;
   assign ptr_next      = (int'(win_idx) == NUM_REQ-1) ? '0 : win_idx + PTR_W'(1);
   // Clearing the lowest set bit leaves something only if two or more were eligible.
   assign conflict_next = |(elig & (elig - NUM_REQ'(1)));

   always_ff @(posedge clk) begin
      // NOTE: registered state uses non-blocking assignments so all flops update together.
      if (rst) begin
         cdb_q      <= '0;
         grant_q    <= '0;
         conflict_q <= 1'b0;
         ptr_q      <= '0;
      end else if (bus.flush) begin
         cdb_q      <= '0;
         grant_q    <= '0;
         conflict_q <= 1'b0;
      end else if (found) begin
         cdb_q      <= {1'b1, win_payload};
         grant_q    <= win_onehot;
         conflict_q <= conflict_next;
         ptr_q      <= ptr_next;
      end else begin
         cdb_q      <= '0;
         grant_q    <= '0;
         conflict_q <= 1'b0;
      end
   end

   assign bus.cdb      = cdb_q;
   assign bus.grant    = grant_q;
   assign bus.conflict = conflict_q;

   a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
   a_valid_matches_grant: assert property (@(posedge clk) disable iff (rst)
      cdb_q[PAYLOAD_W] == (|grant_q));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal expectations,
// then randomized FU traffic compared every cycle against a behavioural model.
module tb_cdb_arbiter;
   localparam int NUM_REQ   = 5;
   localparam int PAYLOAD_W = 38;
   localparam int PTR_W     = 3;

   logic clk;
   logic rst;
   logic [PAYLOAD_W-1:0] pay [NUM_REQ];

   int total = 0;
   int bad   = 0;

   cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .PAYLOAD_W(PAYLOAD_W)) bus ();

   cdb_arbiter #(.NUM_REQ(NUM_REQ), .PAYLOAD_W(PAYLOAD_W), .PTR_W(PTR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) bus.req_payload[i*PAYLOAD_W +: PAYLOAD_W] = pay[i];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: eligible FUs are requesters other than last cycle's winner;
   // winner is the one at the smallest round-robin distance from the pointer.
   logic [PAYLOAD_W:0]  exp_cdb;
   logic [NUM_REQ-1:0]  exp_grant;
   logic                exp_conflict;
   int                  m_ptr, m_last, m_best, m_bestd, m_n, m_d;
   bit                  m_ready = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         exp_cdb = '0; exp_grant = '0; exp_conflict = 1'b0;
         m_ptr = 0; m_last = -1; m_ready = 1'b1;
      end else if (bus.flush) begin
         exp_cdb = '0; exp_grant = '0; exp_conflict = 1'b0;
         m_last = -1;
      end else begin
         m_best = -1; m_bestd = NUM_REQ; m_n = 0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i] && i != m_last) begin
               m_n++;
               m_d = (i - m_ptr + NUM_REQ) % NUM_REQ;
               if (m_d < m_bestd) begin m_bestd = m_d; m_best = i; end
            end
         end
         if (m_best < 0) begin
            exp_cdb = '0; exp_grant = '0; exp_conflict = 1'b0;
            m_last = -1;
         end else begin
            exp_cdb      = {1'b1, pay[m_best]};
            exp_grant    = NUM_REQ'(1) << m_best;
            exp_conflict = (m_n > 1);
            m_last       = m_best;
            m_ptr        = (m_best + 1) % NUM_REQ;
         end
      end
   end

   // Compare process: outputs are registered, so they are stable at the negedge.
   always @(negedge clk) begin
      if (m_ready) begin
         check("model_cdb", 64'(bus.cdb), 64'(exp_cdb));
         check("model_grant", 64'(bus.grant), 64'(exp_grant));
         check("model_conflict", 64'(bus.conflict), 64'(exp_conflict));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; bus.flush = 1'b0; bus.req = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [PAYLOAD_W-1:0] p1, p2;
   logic [PAYLOAD_W:0]   e39;
   int                   seen [NUM_REQ];
   bit                   drop_pending [NUM_REQ];

   initial begin
      rst = 1'b0; bus.flush = 1'b0; bus.req = '0;
      for (int i = 0; i < NUM_REQ; i++) pay[i] = PAYLOAD_W'(64'h11 * (i + 1));

      // Reset state, then a lone FU held: granted every second cycle
      do_reset();
      check("reset_cdb", 64'(bus.cdb), 64'h0);
      check("reset_grant", 64'(bus.grant), 64'h0);
      check("reset_conflict", 64'(bus.conflict), 64'h0);
      p1 = 38'h15_DEAD_BEEF; pay[2] = p1; e39 = {1'b1, p1};
      bus.req = 5'b00100;
      @(negedge clk);
      check("lone_c1_cdb", 64'(bus.cdb), 64'(e39));
      check("lone_c1_grant", 64'(bus.grant), 64'h04);
      check("lone_c1_conflict", 64'(bus.conflict), 64'h0);
      @(negedge clk);
      check("lone_c2_cdb", 64'(bus.cdb), 64'h0);
      @(negedge clk);
      check("lone_c3_cdb", 64'(bus.cdb), 64'(e39));
      check("lone_c3_conflict", 64'(bus.conflict), 64'h0);
      bus.req = '0;

      // Rotation with pointer wrap
      do_reset();
      bus.req = 5'b10011;
      @(negedge clk);
      check("rr_g1", 64'(bus.grant), 64'h01);
      check("rr_conf1", 64'(bus.conflict), 64'h1);
      @(negedge clk);
      check("rr_g2", 64'(bus.grant), 64'h02);
      check("rr_conf2", 64'(bus.conflict), 64'h1);
      @(negedge clk);
      check("rr_g3", 64'(bus.grant), 64'h10);
      check("rr_conf3", 64'(bus.conflict), 64'h1);
      @(negedge clk);
      check("rr_g4_wrap", 64'(bus.grant), 64'h01);
      bus.req = '0;

      // Late-dropping winners: each result broadcast exactly once
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin seen[i] = 0; drop_pending[i] = 1'b0; end
      bus.req = 5'b01010;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (drop_pending[i]) begin bus.req[i] = 1'b0; drop_pending[i] = 1'b0; end
            if (bus.grant[i]) begin seen[i]++; drop_pending[i] = 1'b1; end
         end
      end
      check("once_fu1", 64'(seen[1]), 64'd1);
      check("once_fu3", 64'(seen[3]), 64'd1);
      check("once_fu0", 64'(seen[0]), 64'd0);

      // Flush cancels the broadcast and keeps the pointer
      do_reset();
      bus.req = 5'b00001;
      @(negedge clk);
      check("fl_pre_grant", 64'(bus.grant), 64'h01);
      bus.req = 5'b01001; bus.flush = 1'b1;
      @(negedge clk);
      check("fl_cdb", 64'(bus.cdb), 64'h0);
      check("fl_grant", 64'(bus.grant), 64'h0);
      bus.flush = 1'b0;
      @(negedge clk);
      check("fl_after_grant", 64'(bus.grant), 64'h08);
      bus.req = '0;

      // Reset mid-broadcast restarts at FU0
      do_reset();
      bus.req = 5'b11111;
      @(negedge clk);
      check("rst_pre_grant", 64'(bus.grant), 64'h01);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_cdb", 64'(bus.cdb), 64'h0);
      check("rst_mid_grant", 64'(bus.grant), 64'h0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_after_grant", 64'(bus.grant), 64'h01);
      bus.req = '0;

      // Payload captured at grant
      do_reset();
      p1 = 38'h2A_0123_4567; p2 = 38'h05_89AB_CDEF;
      pay[1] = p1; e39 = {1'b1, p1};
      bus.req = 5'b00010;
      @(negedge clk);
      pay[1] = p2; bus.req = '0;
      #1 check("hold_early", 64'(bus.cdb), 64'(e39));
      #3 check("hold_late", 64'(bus.cdb), 64'(e39));

      // Randomized FU traffic against the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         rst       = ($urandom_range(63) == 0);
         bus.flush = ($urandom_range(15) == 0);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i] && bus.grant[i]) begin
               if ($urandom_range(1) == 0) bus.req[i] = 1'b0;
            end else if (!bus.req[i]) begin
               if ($urandom_range(2) == 0) bus.req[i] = 1'b1;
            end
            if ($urandom_range(1) == 0) pay[i] = PAYLOAD_W'({$urandom, $urandom});
         end
      end
      @(negedge clk);
      rst = 1'b0; bus.flush = 1'b0; bus.req = '0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
